// File: rtl/gng_sign_apply_pipe.sv
// Sign-application output stage: rounded down-scale, sign apply, saturate, 2-stage valid/ready pipe.
// Optional per-handshake statistics counters when GNG_SIGN_STATS_EN is defined.
module gng_sign_apply_pipe #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 0,
  parameter int OUT_W = 17
) (
  input  logic               clk,
  input  logic               rst,
`ifdef GNG_SIGN_STATS_EN
  input  logic               stat_clr,
  output logic [15:0]        stat_pos,
  output logic [15:0]        stat_neg,
  output logic [15:0]        stat_sat,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_product,
  input  logic               in_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_result,
  output logic               out_sat
);

  localparam int SW = (WIDTH + 2 > OUT_W + 1) ? WIDTH + 2 : OUT_W + 1;

  // Half-LSB rounding constant; evaluates to 0 when SHIFT == 0 without a negative shift.
  localparam logic [WIDTH+1:0] RND_X = ({{(WIDTH+1){1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic [WIDTH:0]   RND   = RND_X[WIDTH:0];

  localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic             v1, v2;
  logic [WIDTH:0]   m1;
  logic             s1;
  logic             en1, en2;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   m1_next;
  logic signed [SW-1:0] mag_x, value;
  logic [OUT_W-1:0] res_next;
  logic             sat_next;

  assign en2       = !v2 || out_ready;
  assign en1       = !v1 || en2;
  assign in_ready  = en1 && !rst;
  assign out_valid = v2;

  assign sum     = {1'b0, in_product} + RND;
  assign m1_next = sum >> SHIFT;

  assign mag_x = {{(SW-WIDTH-1){1'b0}}, m1};
  assign value = s1 ? -mag_x : mag_x;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    res_next = value[OUT_W-1:0];
    sat_next = 1'b0;
    if (value > MAXV) begin
      res_next = MAXV[OUT_W-1:0];
      sat_next = 1'b1;
    end else if (value < MINV) begin
      res_next = MINV[OUT_W-1:0];
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep both stages reading pre-edge values of each other.
    if (rst) begin
      v1         <= 1'b0;
      m1         <= '0;
      s1         <= 1'b0;
      v2         <= 1'b0;
      out_result <= '0;
      out_sat    <= 1'b0;
    end else begin
      if (en1) begin
        v1 <= in_valid && in_ready;
        m1 <= m1_next;
        s1 <= in_sign;
      end
      if (en2) begin
        v2         <= v1;
        out_result <= res_next;
        out_sat    <= sat_next;
      end
    end
  end

`ifdef GNG_SIGN_STATS_EN
  logic out_fire, is_pos, is_neg;

  // Saturation preserves sign, so the registered result classifies the pre-clamp value.
  assign out_fire = out_valid && out_ready;
  assign is_neg   = out_result[OUT_W-1];
  assign is_pos   = !out_result[OUT_W-1] && (|out_result);

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_pos <= '0;
      stat_neg <= '0;
      stat_sat <= '0;
    end else if (out_fire) begin
      if (is_pos && stat_pos != 16'hFFFF) stat_pos <= stat_pos + 16'd1;
      if (is_neg && stat_neg != 16'hFFFF) stat_neg <= stat_neg + 16'd1;
      if (out_sat && stat_sat != 16'hFFFF) stat_sat <= stat_sat + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gng_sign_apply_pipe.sv
// Directed bench: three parameterisations (default, OUT_W=16, SHIFT=4) driven by shared stimulus.
module tb_gng_sign_apply_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sign, out_ready;
  logic [15:0] in_product;

  logic        rdy_a, rdy_b, rdy_c;
  logic        vld_a, vld_b, vld_c;
  logic [16:0] res_a;
  logic [15:0] res_b;
  logic [16:0] res_c;
  logic        sat_a, sat_b, sat_c;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef GNG_SIGN_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] pos_a, neg_a, st_a, pos_b, neg_b, st_b, pos_c, neg_c, st_c;
`endif

  gng_sign_apply_pipe u_a (
    .clk(clk), .rst(rst),
`ifdef GNG_SIGN_STATS_EN
    .stat_clr(stat_clr), .stat_pos(pos_a), .stat_neg(neg_a), .stat_sat(st_a),
`endif
    .in_valid(in_valid), .in_ready(rdy_a), .in_product(in_product), .in_sign(in_sign),
    .out_valid(vld_a), .out_ready(out_ready), .out_result(res_a), .out_sat(sat_a)
  );

  gng_sign_apply_pipe #(.WIDTH(16), .SHIFT(0), .OUT_W(16)) u_b (
    .clk(clk), .rst(rst),
`ifdef GNG_SIGN_STATS_EN
    .stat_clr(stat_clr), .stat_pos(pos_b), .stat_neg(neg_b), .stat_sat(st_b),
`endif
    .in_valid(in_valid), .in_ready(rdy_b), .in_product(in_product), .in_sign(in_sign),
    .out_valid(vld_b), .out_ready(out_ready), .out_result(res_b), .out_sat(sat_b)
  );

  gng_sign_apply_pipe #(.WIDTH(16), .SHIFT(4), .OUT_W(17)) u_c (
    .clk(clk), .rst(rst),
`ifdef GNG_SIGN_STATS_EN
    .stat_clr(stat_clr), .stat_pos(pos_c), .stat_neg(neg_c), .stat_sat(st_c),
`endif
    .in_valid(in_valid), .in_ready(rdy_c), .in_product(in_product), .in_sign(in_sign),
    .out_valid(vld_c), .out_ready(out_ready), .out_result(res_c), .out_sat(sat_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_valid(input string tag, input logic v);
    check({tag, "_vld_a"}, {31'd0, vld_a}, {31'd0, v});
    check({tag, "_vld_b"}, {31'd0, vld_b}, {31'd0, v});
    check({tag, "_vld_c"}, {31'd0, vld_c}, {31'd0, v});
  endtask

  task automatic chk_ready(input string tag, input logic r);
    check({tag, "_rdy_a"}, {31'd0, rdy_a}, {31'd0, r});
    check({tag, "_rdy_b"}, {31'd0, rdy_b}, {31'd0, r});
    check({tag, "_rdy_c"}, {31'd0, rdy_c}, {31'd0, r});
  endtask

  task automatic chk_data(input string tag,
                          input logic [16:0] ea, input logic sa,
                          input logic [15:0] eb, input logic sb,
                          input logic [16:0] ec, input logic sc);
    chk_valid(tag, 1'b1);
    check({tag, "_res_a"}, {15'd0, res_a}, {15'd0, ea});
    check({tag, "_sat_a"}, {31'd0, sat_a}, {31'd0, sa});
    check({tag, "_res_b"}, {16'd0, res_b}, {16'd0, eb});
    check({tag, "_sat_b"}, {31'd0, sat_b}, {31'd0, sb});
    check({tag, "_res_c"}, {15'd0, res_c}, {15'd0, ec});
    check({tag, "_sat_c"}, {31'd0, sat_c}, {31'd0, sc});
  endtask

  // Hand-computed vectors: a = default, b = OUT_W 16, c = SHIFT 4 with round-half-up.
  localparam int N = 10;
  logic [15:0] ip [N];
  logic        is [N];
  logic [16:0] ea [N];
  logic [15:0] eb [N];
  logic        sb [N];
  logic [16:0] ec [N];

  initial begin
    ip = '{16'hAF0C, 16'hAF0C, 16'h0000, 16'h8000, 16'h0018,
           16'h0017, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF};
    is = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ea = '{17'h0AF0C, 17'h150F4, 17'h00000, 17'h18000, 17'h00018,
           17'h00017, 17'h0FFFF, 17'h10001, 17'h08000, 17'h07FFF};
    eb = '{16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h0018,
           16'h0017, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
    sb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ec = '{17'h00AF1, 17'h1F50F, 17'h00000, 17'h1F800, 17'h00002,
           17'h00001, 17'h01000, 17'h1F000, 17'h00800, 17'h00800};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_product = '0;
    in_sign    = 1'b0;
    out_ready  = 1'b1;

    // Reset state
    step();
    step();
    chk_valid("rst", 1'b0);
    chk_ready("rst", 1'b0);
    check("rst_res_a", {15'd0, res_a}, 32'd0);
    check("rst_sat_b", {31'd0, sat_b}, 32'd0);
`ifdef GNG_SIGN_STATS_EN
    check("rst_stat_pos", {16'd0, pos_a}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk_ready("post_rst", 1'b1);

    // Full-throughput stream: sample k emerges after the second edge following its presentation.
    for (int k = 1; k <= N + 1; k++) begin
      if (k - 1 < N) begin
        in_valid   = 1'b1;
        in_product = ip[k-1];
        in_sign    = is[k-1];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k == 1) chk_valid("lat1", 1'b0);
      else chk_data($sformatf("stream%0d", k - 2), ea[k-2], 1'b0, eb[k-2], sb[k-2], ec[k-2], 1'b0);
      chk_ready($sformatf("stream_rdy%0d", k), 1'b1);
    end
    step();
    chk_valid("bubble", 1'b0);
`ifdef GNG_SIGN_STATS_EN
    check("st_pos_a", {16'd0, pos_a}, 32'd6);
    check("st_neg_a", {16'd0, neg_a}, 32'd3);
    check("st_sat_a", {16'd0, st_a}, 32'd0);
    check("st_sat_b", {16'd0, st_b}, 32'd5);
`endif

    // Backpressure: A, B accepted, C held off until the stall is released.
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_product = 16'h0100;
    in_sign    = 1'b0;
    step();
    chk_ready("bp_a_acc", 1'b1);
    in_product = 16'h0200;
    step();
    chk_data("bp_hold0", 17'h00100, 1'b0, 16'h0100, 1'b0, 17'h00010, 1'b0);
    chk_ready("bp_full", 1'b0);
    in_product = 16'h0300;
    step();
    step();
    chk_data("bp_hold2", 17'h00100, 1'b0, 16'h0100, 1'b0, 17'h00010, 1'b0);
    chk_ready("bp_full2", 1'b0);
    out_ready = 1'b1;
    #1;
    chk_ready("bp_release", 1'b1);
    step();
    in_valid = 1'b0;
    chk_data("bp_b", 17'h00200, 1'b0, 16'h0200, 1'b0, 17'h00020, 1'b0);
    step();
    chk_data("bp_c", 17'h00300, 1'b0, 16'h0300, 1'b0, 17'h00030, 1'b0);
    step();
    chk_valid("bp_empty", 1'b0);

    // Reset with two samples in flight.
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_product = 16'h1234;
    step();
    step();
    chk_valid("fill", 1'b1);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk_ready("in_rst", 1'b0);
    step();
    chk_valid("flush", 1'b0);
    check("flush_res_a", {15'd0, res_a}, 32'd0);
    check("flush_res_c", {15'd0, res_c}, 32'd0);
`ifdef GNG_SIGN_STATS_EN
    check("flush_stat_pos", {16'd0, pos_a}, 32'd0);
`endif
    rst        = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_product = 16'h0050;
    in_sign    = 1'b1;
    step();
    in_valid = 1'b0;
    chk_valid("rst_lat1", 1'b0);
    step();
    chk_data("rst_lat2", 17'h1FFB0, 1'b0, 16'hFFB0, 1'b0, 17'h1FFFB, 1'b0);
    step();
    chk_valid("rst_done", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
